instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 31 +++
 rtl/instruction_fetch_if_id_reg.sv | 31 +++
 rtl/instruction_fetch.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Consumed by instruction_fetch and if_id_reg.
package instruction_fetch_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP             = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_INC          = 32'd4;
    localparam logic [WORD_W-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] instruction;
        logic [WORD_W-1:0] pcplus4;
    } ifid_payload_t;

    // Sequential PC step; wraps modulo 2^32 by construction.
    function automatic logic [WORD_W-1:0] pc_step(input logic [WORD_W-1:0] pc);
        return pc + PC_INC;
    endfunction

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register with load and bubble controls.
// A bubble wins over a load and leaves the PC+4 field untouched.
module if_id_reg
    import instruction_fetch_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              load,
    input  logic              bubble,
    input  ifid_payload_t     next_entry,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] pcplus4,
    output logic              valid
);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            instruction <= NOP;
            pcplus4     <= '0;
            valid       <= 1'b0;
        end else if (bubble) begin
            instruction <= NOP;
            valid       <= 1'b0;
        end else if (load) begin
            instruction <= next_entry.instruction;
            pcplus4     <= next_entry.pcplus4;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, fetch FSM, one-entry hold buffer, IF/ID register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic        Flush,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemData,
    output logic [31:0] PC,
    output logic [31:0] IfId_Instruction,
    output logic [31:0] IfId_PCPlus4,
    output logic        IfId_Valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic [WORD_W-1:0] pc_next;
    logic [WORD_W-1:0] hold_q;
    logic [WORD_W-1:0] hold_next;
    logic              req_next;
    logic              ifid_load;
    logic              ifid_bubble;
    ifid_payload_t     ifid_next;

    // Next-state, PC and IF/ID control decode.
    always_comb begin
        state_next            = state;
        pc_next               = PC;
        hold_next             = hold_q;
        ifid_load             = 1'b0;
        ifid_bubble           = 1'b0;
        ifid_next.instruction = ImemData;
        ifid_next.pcplus4     = pc_step(PC);

        case (state)
            S_START: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                if (PCSrc) begin
                    pc_next     = word_align(BranchTarget);
                    hold_next   = NOP;
                    ifid_bubble = 1'b1;
                end else if (ImemReady) begin
                    if (Stall) begin
                        hold_next  = ImemData;
                        state_next = S_HOLD;
                    end else if (!Flush) begin
                        ifid_load = 1'b1;
                        pc_next   = pc_step(PC);
                    end
                end else if (!Stall) begin
                    ifid_bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (PCSrc) begin
                    pc_next     = word_align(BranchTarget);
                    hold_next   = NOP;
                    ifid_bubble = 1'b1;
                    state_next  = S_REQ;
                end else if (!Stall) begin
                    // A flush here drops the buffered word; the same PC is refetched.
                    state_next = S_REQ;
                    hold_next  = NOP;
                    if (!Flush) begin
                        ifid_load             = 1'b1;
                        ifid_next.instruction = hold_q;
                        pc_next               = pc_step(PC);
                    end
                end
            end
            default: begin
                state_next = S_START;
            end
        endcase

        if (Flush) begin
            ifid_bubble = 1'b1;
        end

        req_next = (state_next == S_REQ);
    end

    // Request is registered from the next state so reset drops it immediately.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= S_START;
            PC      <= RESET_PC;
            hold_q  <= NOP;
            ImemReq <= 1'b0;
        end else begin
            state   <= state_next;
            PC      <= pc_next;
            hold_q  <= hold_next;
            ImemReq <= req_next;
        end
    end

    assign ImemAddr = PC;

    if_id_reg u_if_id_reg (
        .Clk         (Clk),
        .Rst         (Rst),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .next_entry  (ifid_next),
        .instruction (IfId_Instruction),
        .pcplus4     (IfId_PCPlus4),
        .valid       (IfId_Valid)
    );

`ifdef IF_PERF_CNT_EN
    // Free-running, wrapping event counters.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            FetchCount <= '0;
            StallCount <= '0;
        end else begin
            if (ifid_load && !ifid_bubble) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (Stall) begin
                StallCount <= StallCount + 32'd1;
            end
        end
    end
`endif

endmodule
